// File: rtl/tiny_dnn_buf_pkg.sv
// Shared definitions for the result-buffer blocks: default widths and the
// unload sequencer state encoding.
package tiny_dnn_buf_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } unload_state_e;

endpackage

// File: rtl/unload_fifo.sv
// Two-entry {last, data} FIFO. A word pushed into an empty FIFO is visible at
// the head in the same cycle, so buffer read data reaches the stream without an extra stage.
module unload_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_push_last,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_half,
  output logic              o_empty,
  output logic              o_head_last,
  output logic [DATA_W-1:0] o_head_data
);

  logic [DATA_W-1:0] r_data [2];
  logic [1:0]        r_last;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic w_bypass;
  logic w_store;
  logic w_remove;

  // a word arriving into an empty FIFO and popped at once is never stored
  assign w_bypass = (r_count == 2'd0) && i_push;
  assign w_store  = i_push && !(w_bypass && i_pop);
  assign w_remove = i_pop && !w_bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_last    <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_store) begin
        r_data[r_wr_ptr] <= i_push_data;
        r_last[r_wr_ptr] <= i_push_last;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_remove) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_store} - {1'b0, w_remove};
    end
  end

  assign o_full      = (r_count == 2'd2);
  assign o_half      = (r_count == 2'd1);
  assign o_empty     = (r_count == 2'd0) && !i_push;
  assign o_head_data = w_bypass ? i_push_data : r_data[r_rd_ptr];
  assign o_head_last = w_bypass ? i_push_last : r_last[r_rd_ptr];

endmodule

// File: rtl/dst_unload.sv
// Streams len words from the result buffer, starting at base, out on an
// m_valid/m_ready interface, keeping at most two words outstanding.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing buffer reads, throttled by FIFO space
// FLUSH | all reads issued; draining FIFO, done pulse when empty
module dst_unload #(
  parameter int ADDR_W = tiny_dnn_buf_pkg::ADDR_W,
  parameter int DATA_W = tiny_dnn_buf_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              dst_v,
  output logic [ADDR_W-1:0] dst_a,
  input  logic [DATA_W-1:0] dst_d,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  import tiny_dnn_buf_pkg::*;

  localparam logic [ADDR_W:0]   ONE_WORD = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  unload_state_e     r_state;
  unload_state_e     w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_rd_left;
  logic [ADDR_W:0]   r_tag_left;
  logic              r_inflight;
  logic              r_done;

  logic              w_full;
  logic              w_half;
  logic              w_empty;
  logic              w_head_last;
  logic [DATA_W-1:0] w_head_data;
  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic              w_drained;
  logic              w_start_ok;
  logic              w_done_nxt;

  unload_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_last (r_tag_left == ONE_WORD),
    .i_push_data (dst_d),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_half      (w_half),
    .o_empty     (w_empty),
    .o_head_last (w_head_last),
    .o_head_data (w_head_data)
  );

  assign w_pop = !w_empty && m_ready;
  // words held or on their way, after this cycle's pop
  assign w_occ      = {1'b0, w_full, w_half} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_drained  = (w_occ == 3'd0);
  assign w_start_ok = start && !r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = (len == '0) ? FLUSH : RUN;
        end
      end
      RUN: begin
        w_issue = (w_occ < 3'd2);
        if (w_issue && (r_rd_left == ONE_WORD)) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (w_drained) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_rd_left  <= '0;
      r_tag_left <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      r_done     <= w_done_nxt;
      if ((r_state == IDLE) && w_start_ok) begin
        r_addr     <= base;
        r_rd_left  <= len;
        r_tag_left <= len;
      end else begin
        if (w_issue) begin
          r_addr    <= r_addr + ADDR_ONE;
          r_rd_left <= r_rd_left - ONE_WORD;
        end
        // counts words as they land so the final one carries the last tag
        if (r_inflight) begin
          r_tag_left <= r_tag_left - ONE_WORD;
        end
      end
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign dst_v   = w_issue;
  assign dst_a   = r_addr;
  assign m_valid = !w_empty;
  assign m_data  = w_head_data;
  assign m_last  = !w_empty && w_head_last;

endmodule

// File: tb/tb_dst_unload.sv
// Bench for dst_unload: buffer responder, per-cycle stream model and
// directed unload scenarios with literal expectations.
module tb_dst_unload;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          m_ready = 1'b1;
  logic [AW-1:0] base    = '0;
  logic [AW:0]   len     = '0;
  logic [DW-1:0] dst_d   = '0;
  logic          busy, done, dst_v, m_valid, m_last;
  logic [AW-1:0] dst_a;
  logic [DW-1:0] m_data;

  dst_unload #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .dst_v(dst_v), .dst_a(dst_a), .dst_d(dst_d),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [DW-1:0] mem [4096];

  // buffer model: read data appears in the cycle after the strobe, held otherwise
  logic          pend_v = 1'b0;
  logic [AW-1:0] pend_a = '0;
  always @(negedge clk) begin
    pend_v = dst_v;
    pend_a = dst_a;
  end
  always @(posedge clk) begin
    #1;
    if (pend_v) dst_d = mem[pend_a];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
  endtask

  // stream model state
  bit            m_act = 0;
  int            m_base, m_len, m_rd, m_wd;
  int            s_cyc = 0;
  int            done_exp = -1;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  bit            done_seen = 0;
  int            done_rel = -1;
  logic [AW-1:0] a_log [$];
  int            a_cyc [$];
  logic [DW-1:0] d_log [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dst_v", dst_v, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_dst_a", dst_a, 0);
      chk("rst_m_data", m_data, 0);
      m_act      = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
      end
      if (m_last && !m_valid) fail("last_without_valid");
      if (m_act && m_len > 0 && cyc == s_cyc + 1) chk("first_dst_v", dst_v, 1);
      if (m_act && m_len > 0 && cyc == s_cyc + 2) chk("first_m_valid", m_valid, 1);
      if (m_valid) begin
        if (!m_act || m_wd >= m_len) fail("m_valid_spurious");
        else begin
          chk("m_data", m_data, mem[(m_base + m_wd) % 4096]);
          chk("m_last", m_last, (m_wd == m_len - 1));
          if (m_ready) begin
            d_log.push_back(m_data);
            m_wd++;
            if (m_wd == m_len) done_exp = cyc + 1;
          end
        end
      end
      if (dst_v) begin
        if (!m_act || cyc <= s_cyc || m_rd >= m_len) fail("dst_v_spurious");
        else begin
          chk("dst_a", dst_a, (m_base + m_rd) % 4096);
          a_log.push_back(dst_a);
          a_cyc.push_back(cyc);
          m_rd++;
          chk("outstanding_le2", (m_rd - m_wd) <= 2, 1);
        end
      end
      chk("busy", busy, m_act && cyc > s_cyc && cyc != done_exp);
      if (done) begin
        if (!m_act || cyc != done_exp) fail("done_timing");
        else chk("reads_at_done", m_rd, m_len);
        done_seen = 1;
        done_rel  = cyc - s_cyc;
        m_act     = 0;
      end else if (m_act && done_exp >= 0 && cyc >= done_exp) begin
        fail("done_missing");
        m_act = 0;
      end
      if (start && !m_act && !done) begin
        m_act    = 1;
        m_base   = int'(base);
        m_len    = int'(len);
        m_rd     = 0;
        m_wd     = 0;
        s_cyc    = cyc;
        done_exp = (len == 0) ? cyc + 2 : -1;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic clear_logs();
    a_log.delete();
    a_cyc.delete();
    d_log.delete();
    done_seen = 0;
    done_rel  = -1;
  endtask

  // mode 0: ready always; 1: ready pattern 1,0,0; 2: random ready
  task automatic run(input logic [AW-1:0] b, input int l, input int mode, input int extra_at);
    int k;
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1; base = b; len = (AW+1)'(l); m_ready = 1'b1;
    k = 0;
    while (!done_seen && k < 3 * l + 20) begin
      @(posedge clk); #1;
      k++;
      start = (k == extra_at);
      base  = 12'h555;
      len   = 13'd3;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
    start = 1'b0;
    m_ready = 1'b1;
    if (!done_seen) fail("done_timeout");
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_dst_v"}, dst_v, 0);
    chk({nm, "_dst_a"}, dst_a, 0);
    chk({nm, "_m_valid"}, m_valid, 0);
    chk({nm, "_m_last"}, m_last, 0);
    chk({nm, "_m_data"}, m_data, 0);
  endtask

  initial begin
    logic [DW-1:0] ex1_d [4];
    logic [AW-1:0] ex2_a [4];
    int k;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0003;
    mem[16'h10] = 32'hAAAA_0000;
    mem[16'h11] = 32'hBBBB_0001;
    mem[16'h12] = 32'hCCCC_0002;
    mem[16'h13] = 32'hDDDD_0003;
    ex1_d = '{32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003};
    ex2_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run(12'h010, 4, 0, 0);
    chk("ex1_nreads", a_log.size(), 4);
    chk("ex1_nwords", d_log.size(), 4);
    for (int i = 0; i < 4 && i < a_log.size(); i++) begin
      chk("ex1_addr", a_log[i], 12'h010 + 12'(i));
      chk("ex1_addr_cycle", a_cyc[i] - s_cyc, i + 1);
    end
    for (int i = 0; i < 4 && i < d_log.size(); i++) chk("ex1_data", d_log[i], ex1_d[i]);
    chk("ex1_done_rel", done_rel, 6);

    run(12'hFFE, 4, 0, 0);
    chk("wrap_nreads", a_log.size(), 4);
    for (int i = 0; i < 4 && i < a_log.size(); i++) chk("wrap_addr", a_log[i], ex2_a[i]);
    chk("wrap_done_rel", done_rel, 6);

    run(12'h100, 8, 1, 3);
    chk("stall_nreads", a_log.size(), 8);
    chk("stall_nwords", d_log.size(), 8);

    run(12'h300, 0, 0, 1);
    chk("len0_done_rel", done_rel, 2);
    chk("len0_nreads", a_log.size(), 0);
    chk("len0_nwords", d_log.size(), 0);

    run(12'h123, 4096, 0, 0);
    chk("full_nwords", d_log.size(), 4096);
    chk("full_done_rel", done_rel, 4098);

    run(12'h7FD, 5, 2, 0);
    chk("rand_nwords", d_log.size(), 5);

    clear_logs();
    @(posedge clk); #1;
    start = 1'b1; base = 12'h200; len = 13'd10; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (m_wd < 3 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (m_wd < 3) fail("abort_setup_timeout");
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    repeat (2) @(posedge clk);
    #1;
    check_zero("abort_hold");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", done_seen, 0);
    chk("abort_idle_busy", busy, 0);

    run(12'h400, 2, 0, 0);
    chk("post_abort_nwords", d_log.size(), 2);
    chk("post_abort_done_rel", done_rel, 4);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
